// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - IF/ID fields and write-back bus feeding the decode stage
//
// Carries the fetched instruction fields plus the write-back port of the register file.
//   master : driven by fetch / write-back logic (or a testbench)
//   slave  : consumed by id_stage
// Signals: rs1_i, rs2_i, rd_i, Instr31_7_i, op_i, funct3_i, PC_i, pcPlus4_i,
//          wbEn_i, wbRd_i, wbData_i

interface id_stage_if #(
    parameter int DATA_W = 32
);
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [4:0]        rd_i;
    logic [24:0]       Instr31_7_i;
    logic [6:0]        op_i;
    logic [2:0]        funct3_i;
    logic [DATA_W-1:0] PC_i;
    logic [DATA_W-1:0] pcPlus4_i;
    logic              wbEn_i;
    logic [4:0]        wbRd_i;
    logic [DATA_W-1:0] wbData_i;

    modport master (
        output rs1_i, rs2_i, rd_i, Instr31_7_i, op_i, funct3_i, PC_i, pcPlus4_i,
               wbEn_i, wbRd_i, wbData_i
    );

    modport slave (
        input  rs1_i, rs2_i, rd_i, Instr31_7_i, op_i, funct3_i, PC_i, pcPlus4_i,
               wbEn_i, wbRd_i, wbData_i
    );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: register file, decode, load-use stall, ID/EX register
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             squash the instruction currently in ID
//   ifid                IF/ID fields and write-back bus (id_stage_if.slave)
//   PCEn_o, IF_ID_En_o  combinational fetch enables (low during a load-use stall)
//   *_o (remaining)     ID/EX pipeline register: operands, immediate, PCs, indices, controls

module id_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    id_stage_if.slave         ifid,
    output logic              PCEn_o,
    output logic              IF_ID_En_o,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] PC_o,
    output logic [DATA_W-1:0] pcPlus4_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              Branch_o,
    output logic              Jump_o,
    output logic              JumpReg_o,
    output logic              ALUSrcA_o,
    output logic              ALUSrcB_o,
    output logic [1:0]        ResultSrc_o,
    output logic [3:0]        ALUCtrl_o,
    output logic              Illegal_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [DATA_W-1:0] regs [NREGS];
    logic [31:0]       instr;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic              reg_write, mem_read, mem_write, branch, jump, jump_reg;
    logic              alu_src_a, alu_src_b, illegal, uses_rs1, uses_rs2, stall;
    logic [1:0]        result_src;
    logic [3:0]        alu_ctrl, alu_arith;

    assign instr = {ifid.Instr31_7_i, ifid.op_i};

    // Read ports bypass a same-cycle write so the writer and reader need not be one apart.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ifid.rs1_i != 5'd0)
            rd1 = (ifid.wbEn_i && ifid.wbRd_i == ifid.rs1_i) ? ifid.wbData_i : regs[ifid.rs1_i];
        if (ifid.rs2_i != 5'd0)
            rd2 = (ifid.wbEn_i && ifid.wbRd_i == ifid.rs2_i) ? ifid.wbData_i : regs[ifid.rs2_i];
    end

    // funct3 -> ALU op for OP / OP-IMM; bit 30 selects SUB (register form only) and SRA.
    always_comb begin
        case (ifid.funct3_i)
            3'b000:  alu_arith = (ifid.op_i == OP_REG && instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_arith = 4'd2;
            3'b010:  alu_arith = 4'd3;
            3'b011:  alu_arith = 4'd4;
            3'b100:  alu_arith = 4'd5;
            3'b101:  alu_arith = instr[30] ? 4'd7 : 4'd6;
            3'b110:  alu_arith = 4'd8;
            default: alu_arith = 4'd9;
        endcase
    end

    always_comb begin
        imm        = '0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        result_src = 2'd0;
        alu_ctrl   = ALU_ADD;
        illegal    = 1'b0;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b0;
        case (ifid.op_i)
            OP_LUI: begin
                imm = {instr[31:12], 12'b0};
                reg_write = 1'b1; alu_src_b = 1'b1; alu_ctrl = ALU_PASSB; uses_rs1 = 1'b0;
            end
            OP_AUIPC: begin
                imm = {instr[31:12], 12'b0};
                reg_write = 1'b1; alu_src_a = 1'b1; alu_src_b = 1'b1; uses_rs1 = 1'b0;
            end
            OP_JAL: begin
                imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                reg_write = 1'b1; jump = 1'b1; result_src = 2'd2; uses_rs1 = 1'b0;
            end
            OP_JALR: begin
                imm = {{20{instr[31]}}, instr[31:20]};
                reg_write = 1'b1; jump_reg = 1'b1; alu_src_b = 1'b1; result_src = 2'd2;
            end
            OP_BRANCH: begin
                imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                branch = 1'b1; alu_ctrl = ALU_SUB; uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                imm = {{20{instr[31]}}, instr[31:20]};
                reg_write = 1'b1; mem_read = 1'b1; alu_src_b = 1'b1; result_src = 2'd1;
            end
            OP_STORE: begin
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                mem_write = 1'b1; alu_src_b = 1'b1; uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                imm = {{20{instr[31]}}, instr[31:20]};
                reg_write = 1'b1; alu_src_b = 1'b1; alu_ctrl = alu_arith;
            end
            OP_REG: begin
                reg_write = 1'b1; alu_ctrl = alu_arith; uses_rs2 = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Flush wins over stall so the EX redirect is never blocked by a hazard on a dead instruction.
    assign stall = MemRead_o && rd_o != 5'd0 && !flush_i &&
                   ((rd_o == ifid.rs1_i && uses_rs1) || (rd_o == ifid.rs2_i && uses_rs2));
    assign PCEn_o     = !stall;
    assign IF_ID_En_o = !stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (ifid.wbEn_i && ifid.wbRd_i != 5'd0) begin
            regs[ifid.wbRd_i] <= ifid.wbData_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || stall || flush_i) begin
            rd1_o <= '0; rd2_o <= '0; imm_o <= '0; PC_o <= '0; pcPlus4_o <= '0;
            rs1_o <= '0; rs2_o <= '0; rd_o <= '0; funct3_o <= '0;
            RegWrite_o <= 1'b0; MemRead_o <= 1'b0; MemWrite_o <= 1'b0;
            Branch_o <= 1'b0; Jump_o <= 1'b0; JumpReg_o <= 1'b0;
            ALUSrcA_o <= 1'b0; ALUSrcB_o <= 1'b0; ResultSrc_o <= '0;
            ALUCtrl_o <= '0; Illegal_o <= 1'b0;
        end else begin
            rd1_o <= rd1; rd2_o <= rd2; imm_o <= imm;
            PC_o <= ifid.PC_i; pcPlus4_o <= ifid.pcPlus4_i;
            rs1_o <= ifid.rs1_i; rs2_o <= ifid.rs2_i; rd_o <= ifid.rd_i;
            funct3_o <= ifid.funct3_i;
            RegWrite_o <= reg_write; MemRead_o <= mem_read; MemWrite_o <= mem_write;
            Branch_o <= branch; Jump_o <= jump; JumpReg_o <= jump_reg;
            ALUSrcA_o <= alu_src_a; ALUSrcB_o <= alu_src_b; ResultSrc_o <= result_src;
            ALUCtrl_o <= alu_ctrl; Illegal_o <= illegal;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage

module tb_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    id_stage_if ifid ();

    logic        pc_en, ifid_en;
    logic [31:0] rd1_o, rd2_o, imm_o, pc_o, pcp4_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [2:0]  f3_o;
    logic        rw_o, mr_o, mw_o, br_o, j_o, jr_o, sa_o, sb_o, ill_o;
    logic [1:0]  rsrc_o;
    logic [3:0]  alu_o;

    id_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ifid(ifid),
        .PCEn_o(pc_en), .IF_ID_En_o(ifid_en),
        .rd1_o(rd1_o), .rd2_o(rd2_o), .imm_o(imm_o), .PC_o(pc_o), .pcPlus4_o(pcp4_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(f3_o),
        .RegWrite_o(rw_o), .MemRead_o(mr_o), .MemWrite_o(mw_o),
        .Branch_o(br_o), .Jump_o(j_o), .JumpReg_o(jr_o),
        .ALUSrcA_o(sa_o), .ALUSrcB_o(sb_o), .ResultSrc_o(rsrc_o),
        .ALUCtrl_o(alu_o), .Illegal_o(ill_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected ID/EX contents as the spec describes them: instruction word in, fields out.
    logic [31:0] m_rf [32];
    logic        m_valid = 1'b0;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pcp4;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]  e_f3;
    logic [10:0] e_ctl;  // {rw, mr, mw, br, j, jr, sa, sb, rsrc[1:0], ill}
    logic [3:0]  e_alu;

    function automatic logic [10:0] m_ctl(input logic [6:0] op);
        case (op)
            7'h37:   return 11'b1_0_0_0_0_0_0_1_00_0;
            7'h17:   return 11'b1_0_0_0_0_0_1_1_00_0;
            7'h6F:   return 11'b1_0_0_0_1_0_0_0_10_0;
            7'h67:   return 11'b1_0_0_0_0_1_0_1_10_0;
            7'h63:   return 11'b0_0_0_1_0_0_0_0_00_0;
            7'h03:   return 11'b1_1_0_0_0_0_0_1_01_0;
            7'h23:   return 11'b0_0_1_0_0_0_0_1_00_0;
            7'h13:   return 11'b1_0_0_0_0_0_0_1_00_0;
            7'h33:   return 11'b1_0_0_0_0_0_0_0_00_0;
            default: return 11'b0_0_0_0_0_0_0_0_00_1;
        endcase
    endfunction

    function automatic logic [3:0] m_alu(input logic [31:0] w);
        logic [3:0] tab [8];
        logic [3:0] r;
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (w[6:0] == 7'h37) return 4'd10;
        if (w[6:0] == 7'h63) return 4'd1;
        if (w[6:0] != 7'h13 && w[6:0] != 7'h33) return 4'd0;
        r = tab[w[14:12]];
        if (w[14:12] == 3'd0 && w[6:0] == 7'h33 && w[30]) r = 4'd1;
        if (w[14:12] == 3'd5 && w[30]) r = 4'd7;
        return r;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] w);
        logic [31:0] sx;
        sx = $signed(w) >>> 20;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: return sx;
            7'h23:        return {sx[31:5], w[11:7]};
            7'h63:        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            7'h37, 7'h17: return w & 32'hFFFF_F000;
            7'h6F:        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            default:      return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (ifid.wbEn_i && ifid.wbRd_i == r) return ifid.wbData_i;
        return m_rf[r];
    endfunction

    function automatic logic m_stall();
        logic [6:0] op;
        logic u1, u2;
        op = ifid.op_i;
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h63 || op == 7'h23 || op == 7'h33);
        return e_ctl[9] && e_rd != 0 && !flush &&
               ((e_rd == ifid.rs1_i && u1) || (e_rd == ifid.rs2_i && u2));
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        w = {ifid.Instr31_7_i, ifid.op_i};
        if (rst) begin
            m_valid = 1'b1;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            {e_rd1, e_rd2, e_imm, e_pc, e_pcp4} = '0;
            {e_rs1, e_rs2, e_rd, e_f3, e_ctl, e_alu} = '0;
        end else begin
            if (m_stall() || flush) begin
                {e_rd1, e_rd2, e_imm, e_pc, e_pcp4} = '0;
                {e_rs1, e_rs2, e_rd, e_f3, e_ctl, e_alu} = '0;
            end else begin
                e_rd1 = m_read(ifid.rs1_i); e_rd2 = m_read(ifid.rs2_i);
                e_imm = m_imm(w); e_pc = ifid.PC_i; e_pcp4 = ifid.pcPlus4_i;
                e_rs1 = ifid.rs1_i; e_rs2 = ifid.rs2_i; e_rd = ifid.rd_i;
                e_f3 = ifid.funct3_i; e_ctl = m_ctl(ifid.op_i); e_alu = m_alu(w);
            end
            if (ifid.wbEn_i && ifid.wbRd_i != 0) m_rf[ifid.wbRd_i] = ifid.wbData_i;
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pcen",  {31'b0, pc_en},   {31'b0, !m_stall()});
            chk("ifiden", {31'b0, ifid_en}, {31'b0, !m_stall()});
            chk("rd1", rd1_o, e_rd1);
            chk("rd2", rd2_o, e_rd2);
            chk("imm", imm_o, e_imm);
            chk("pc", pc_o, e_pc);
            chk("pcp4", pcp4_o, e_pcp4);
            chk("idx", {17'b0, rs1_o, rs2_o, rd_o}, {17'b0, e_rs1, e_rs2, e_rd});
            chk("funct3", {29'b0, f3_o}, {29'b0, e_f3});
            chk("ctl", {21'b0, rw_o, mr_o, mw_o, br_o, j_o, jr_o, sa_o, sb_o, rsrc_o, ill_o},
                {21'b0, e_ctl});
            chk("aluctrl", {28'b0, alu_o}, {28'b0, e_alu});
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] pc = 32'h1000;

    task automatic issue(input logic [31:0] w);
        ifid.Instr31_7_i = w[31:7];
        ifid.op_i        = w[6:0];
        ifid.rs1_i       = w[19:15];
        ifid.rs2_i       = w[24:20];
        ifid.rd_i        = w[11:7];
        ifid.funct3_i    = w[14:12];
        ifid.PC_i        = pc;
        ifid.pcPlus4_i   = pc + 32'd4;
        pc = pc + 32'd4;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        ifid.wbEn_i = en; ifid.wbRd_i = r; ifid.wbData_i = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] LW_X3   = 32'h0000A183;  // lw   x3,0(x1)
    localparam logic [31:0] ADD_X4  = 32'h00218233;  // add  x4,x3,x2
    localparam logic [31:0] ADDI_X7 = 32'h00500393;  // addi x7,x0,5
    localparam logic [31:0] RD_X5   = 32'h00028313;  // addi x6,x5,0
    localparam logic [31:0] RD_X0   = 32'h00000093;  // addi x1,x0,0

    logic [31:0] sweep [8];

    initial begin
        issue(32'h0000_0013);
        wb(1'b1, 5'd5, 32'hCAFE_F00D);  // write-back during reset must be dropped
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        chk("rst_rd1", rd1_o, 32'h0);
        chk("rst_regwrite", {31'b0, rw_o}, 32'h0);
        chk("rst_pcen", {30'b0, pc_en, ifid_en}, 32'h3);

        issue(RD_X5); tick();
        chk("x5_after_reset", rd1_o, 32'h0);

        issue(RD_X5); wb(1'b1, 5'd5, 32'hDEAD_BEEF); tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("bypass_x5", rd1_o, 32'hDEAD_BEEF);
        issue(RD_X5); tick();
        chk("array_x5", rd1_o, 32'hDEAD_BEEF);

        issue(RD_X0); wb(1'b1, 5'd0, 32'h1234); tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("x0_zero", rd1_o, 32'h0);
        issue(RD_X0); tick();
        chk("x0_zero_array", rd1_o, 32'h0);

        // load-use: one stall cycle, one bubble, then the add issues
        issue(LW_X3); tick();
        issue(ADD_X4); #1;
        chk("lu_pcen", {30'b0, pc_en, ifid_en}, 32'h0);
        tick();
        chk("lu_bubble", {26'b0, rw_o, rd_o}, 32'h0);
        chk("lu_release", {30'b0, pc_en, ifid_en}, 32'h3);
        tick();
        chk("lu_add_rd", {27'b0, rd_o}, 32'd4);
        chk("lu_add_rw", {31'b0, rw_o}, 32'h1);

        // flush overrides a pending load-use stall
        issue(LW_X3); tick();
        issue(ADD_X4); flush = 1'b1; #1;
        chk("flush_pcen", {30'b0, pc_en, ifid_en}, 32'h3);
        tick();
        chk("flush_bubble", {26'b0, rw_o, rd_o}, 32'h0);
        issue(ADDI_X7); tick();
        flush = 1'b0;
        chk("flush_addi", {25'b0, rw_o, sb_o, rd_o}, 32'h0);

        issue(32'hFE0008E3); tick();  // beq x0,x0,-16
        chk("beq_imm", imm_o, 32'hFFFF_FFF0);
        chk("beq_ctl", {27'b0, br_o, alu_o}, 32'h11);

        issue(32'h123450B7); tick();  // lui x1,0x12345
        chk("lui_imm", imm_o, 32'h1234_5000);
        chk("lui_alu", {28'b0, alu_o}, 32'd10);

        issue(32'h0000007F); tick();
        chk("ill_set", {31'b0, ill_o}, 32'h1);
        chk("ill_ctl", {24'b0, rw_o, mr_o, mw_o, br_o, j_o, jr_o, sa_o, sb_o}, 32'h0);
        issue(ADDI_X7); tick();
        chk("ill_clear", {31'b0, ill_o}, 32'h0);

        // remaining formats, checked by the model only; write-backs vary the operands
        sweep = '{32'h407302B3, 32'h4034D413, 32'h0020A423, 32'h004100E7,
                  32'h00001117, 32'h008000EF, 32'h0034D413, 32'h00218233};
        for (int i = 0; i < 8; i++) begin
            issue(sweep[i]);
            wb(1'b1, 5'(i + 1), 32'h1111_0000 + 32'(i));
            tick();
        end
        wb(1'b0, 5'd0, 32'h0);

        // reset in the middle of a stall: stall bubble discarded, add proceeds next cycle
        issue(LW_X3); tick();
        issue(ADD_X4); rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst_stall", {25'b0, mr_o, rw_o, rd_o}, 32'h0);
        chk("rst_stall_pcen", {30'b0, pc_en, ifid_en}, 32'h3);
        tick();
        chk("rst_stall_add", {27'b0, rd_o}, 32'd4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
